// File: rtl/apb_mem_slave.sv
// APB slave fronting a byte-strobed word RAM, with a fixed number of wait states per access.
// Define APB_MEM_SLVERR_EN to flag misaligned or out-of-window accesses with PSLVERR.
module apb_mem_slave #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                DEPTH       = 256,
   parameter int                WAIT_STATES = 0,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_W-1:0]     PADDR,
   input  logic [DATA_W-1:0]     PWDATA,
   input  logic [DATA_W/8-1:0]   PSTRB,
   output logic [DATA_W-1:0]     PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int NB      = DATA_W / 8;
   localparam int BYTE_SH = $clog2(NB);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(DEPTH * NB);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                write_q, write_d;
   logic                err_q, err_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                mem_we;
   logic [DATA_W-1:0]   mem_wdat;
   logic [ADDR_W-1:0]   off;
   logic [IDX_W-1:0]    idx_a;
   logic                err_a;

   assign off   = PADDR - BASE_ADDR;
   assign idx_a = IDX_W'(off >> BYTE_SH);

`ifdef APB_MEM_SLVERR_EN
   assign err_a = (PADDR < BASE_ADDR) || ({1'b0, off} >= WIN_BYTES) ||
                  ((off & ADDR_W'(NB - 1)) != '0);
`else
   // Without the error feature the byte offset and upper offset bits are don't-care.
   logic unused_off;
   assign unused_off = ^off;
   assign err_a      = 1'b0;
`endif

   assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign PSLVERR = PREADY && err_q;
   assign PRDATA  = prdata_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      write_d  = write_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      prdata_d = prdata_q;
      mem_we   = 1'b0;
      mem_wdat = mem_q[idx_q];
      for (int k = 0; k < NB; k++) begin
         if (PSTRB[k]) mem_wdat[8*k +: 8] = PWDATA[8*k +: 8];
      end
      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               idx_d   = idx_a;
               write_d = PWRITE;
               err_d   = err_a;
               cnt_d   = 4'(WAIT_STATES);
               state_d = ACCESS;
               if (!PWRITE) prdata_d = err_a ? '0 : mem_q[idx_a];
            end
         end
         ACCESS: begin
            // Losing PSEL mid-access abandons the transfer silently.
            if (!PSEL) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (PENABLE) begin
               state_d = IDLE;
               mem_we  = write_q && !err_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= 4'd0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         write_q  <= write_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         prdata_q <= prdata_d;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[idx_q] <= mem_wdat;
      end
   end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: a zero-wait instance (index 0) and a three-wait instance (index 1)
// share the APB bus except for PSEL; expectations flow through a scoreboard queue.
module tb_apb_mem_slave;

`ifdef APB_MEM_SLVERR_EN
   localparam bit SLV = 1'b1;
`else
   localparam bit SLV = 1'b0;
`endif

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [1:0]  psel;
   logic        PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] rd0, rd3;
   logic        pr0, pr3, se0, se3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        chk;
      logic [31:0] data;
      logic        err;
      int          waits;
   } exp_t;

   typedef struct {
      int          d;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  st;
      logic        chk;
      logic [31:0] exp;
      logic        err;
      int          waits;
   } step_t;

   exp_t sb[$];

   always #5 PCLK = ~PCLK;

   apb_mem_slave u0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rd0), .PREADY(pr0), .PSLVERR(se0)
   );

   apb_mem_slave #(.WAIT_STATES(3)) u3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rd3), .PREADY(pr3), .PSLVERR(se3)
   );

   function automatic logic rdy(input int d);
      return (d != 0) ? pr3 : pr0;
   endfunction

   // Setup, then access until PREADY; returns with the bus still in the ready cycle.
   task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er,
                       output int waits, output logic tmo);
      @(posedge PCLK); #1;
      psel    = 2'b00;
      psel[d] = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = a;
      PWDATA  = wd;
      PSTRB   = st;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits   = 0;
      tmo     = 1'b0;
      while (!rdy(d)) begin
         if (waits == 20) begin
            tmo = 1'b1;
            break;
         end
         @(posedge PCLK); #1;
         waits++;
      end
      rd = (d != 0) ? rd3 : rd0;
      er = (d != 0) ? se3 : se0;
   endtask

   task automatic idle();
      @(posedge PCLK); #1;
      psel    = 2'b00;
      PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      psel    = 2'b00;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PWDATA  = '0;
      PSTRB   = '0;
      repeat (2) @(posedge PCLK);
      #2;
      total++;
      if ({pr0, se0, rd0, pr3, se3, rd3} !== 68'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", {pr0, se0, rd0, pr3, se3, rd3});
      end
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
      total++;
      if ({pr0, se0, pr3, se3} !== 4'b0) begin
         bad++;
         $display("FAIL reset_idle_ready got=%b exp=0000", {pr0, se0, pr3, se3});
      end
   endtask

   task automatic test_basic_rw();
      step_t s [8];
      exp_t e;
      logic [31:0] rd;
      logic er, t;
      int w;
      s[0] = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 0};
      s[1] = '{0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0};
      s[2] = '{0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 0};
      s[3] = '{0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b1, 32'hDEADBEEF, 1'b0, 0};
      s[4] = '{0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 32'h11BB33DD, 1'b0, 0};
      s[5] = '{0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1'b0, 0};
      s[6] = '{0, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 0};
      s[7] = '{0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0};
      for (int i = 0; i < 8; i++) begin
         sb.push_back('{s[i].chk, s[i].exp, s[i].err, s[i].waits});
         xfer(s[i].d, s[i].wr, s[i].a, s[i].wd, s[i].st, rd, er, w, t);
         e = sb.pop_front();
         total++;
         if (t || w != e.waits) begin
            bad++;
            $display("FAIL basic[%0d] waits got=%0d exp=%0d timeout=%0b", i, w, e.waits, t);
         end
         total++;
         if (er !== e.err) begin
            bad++;
            $display("FAIL basic[%0d] pslverr got=%b exp=%b", i, er, e.err);
         end
         if (e.chk) begin
            total++;
            if (rd !== e.data) begin
               bad++;
               $display("FAIL basic[%0d] prdata got=%h exp=%h", i, rd, e.data);
            end
         end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      step_t s [5];
      exp_t e;
      logic [31:0] rd;
      logic er, t;
      int w;
      s[0] = '{0, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0, 0};
      s[1] = '{0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0, 0};
      s[2] = '{0, 1'b1, 32'h8, 32'h01020304, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 0};
      s[3] = '{0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h01020304, 1'b0, 0};
      s[4] = '{0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0, 0};
      for (int i = 0; i < 5; i++) begin
         sb.push_back('{s[i].chk, s[i].exp, s[i].err, s[i].waits});
         xfer(s[i].d, s[i].wr, s[i].a, s[i].wd, s[i].st, rd, er, w, t);
         e = sb.pop_front();
         total++;
         if (t || w != e.waits) begin
            bad++;
            $display("FAIL b2b[%0d] waits got=%0d exp=%0d timeout=%0b", i, w, e.waits, t);
         end
         total++;
         if (er !== e.err) begin
            bad++;
            $display("FAIL b2b[%0d] pslverr got=%b exp=%b", i, er, e.err);
         end
         if (e.chk) begin
            total++;
            if (rd !== e.data) begin
               bad++;
               $display("FAIL b2b[%0d] prdata got=%h exp=%h", i, rd, e.data);
            end
         end
      end
      idle();
   endtask

   task automatic test_wait_states();
      step_t s [2];
      exp_t e;
      logic [31:0] rd;
      logic er, t;
      int w;
      s[0] = '{1, 1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 1'b0, 3};
      s[1] = '{1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 3};
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{s[i].chk, s[i].exp, s[i].err, s[i].waits});
         xfer(s[i].d, s[i].wr, s[i].a, s[i].wd, s[i].st, rd, er, w, t);
         e = sb.pop_front();
         total++;
         if (t || w != e.waits) begin
            bad++;
            $display("FAIL wait[%0d] waits got=%0d exp=%0d timeout=%0b", i, w, e.waits, t);
         end
         total++;
         if (er !== e.err) begin
            bad++;
            $display("FAIL wait[%0d] pslverr got=%b exp=%b", i, er, e.err);
         end
         if (e.chk) begin
            total++;
            if (rd !== e.data) begin
               bad++;
               $display("FAIL wait[%0d] prdata got=%h exp=%h", i, rd, e.data);
            end
         end
      end
      // Reset arrives two wait cycles into a write.
      @(posedge PCLK); #1;
      psel    = 2'b10;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 32'hC;
      PWDATA  = 32'h5A5A5A5A;
      PSTRB   = 4'hF;
      for (int c = 0; c < 2; c++) begin
         @(posedge PCLK); #1;
         PENABLE = 1'b1;
         total++;
         if (pr3 !== 1'b0) begin
            bad++;
            $display("FAIL wait_cycle[%0d] pready got=%b exp=0", c, pr3);
         end
      end
      PRESETn = 1'b0;
      #1;
      total++;
      if (pr3 !== 1'b0 || se3 !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_xfer ready/err got=%b%b exp=00", pr3, se3);
      end
      @(posedge PCLK); #1;
      psel    = 2'b00;
      PENABLE = 1'b0;
      PRESETn = 1'b1;
      sb.push_back('{1'b1, 32'h0, 1'b0, 3});
      xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, w, t);
      e = sb.pop_front();
      total++;
      if (t || w != e.waits || er !== e.err || rd !== e.data) begin
         bad++;
         $display("FAIL reset_write_lost got=%h/%0d/%b exp=%h/%0d/%b", rd, w, er, e.data, e.waits, e.err);
      end
      idle();
   endtask

   task automatic test_slverr();
      step_t s [5];
      exp_t e;
      logic [31:0] rd;
      logic er, t;
      int w;
      s[0] = '{0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, 0};
      s[1] = '{0, 1'b1, 32'h400, 32'h12345678, 4'hF, 1'b0, 32'h0, SLV, 0};
      s[2] = '{0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, SLV ? 32'h0 : 32'h12345678, SLV, 0};
      s[3] = '{0, 1'b1, 32'h402, 32'h9ABCDEF0, 4'hF, 1'b0, 32'h0, SLV, 0};
      s[4] = '{0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, SLV ? 32'h0BADF00D : 32'h9ABCDEF0, 1'b0, 0};
      for (int i = 0; i < 5; i++) begin
         sb.push_back('{s[i].chk, s[i].exp, s[i].err, s[i].waits});
         xfer(s[i].d, s[i].wr, s[i].a, s[i].wd, s[i].st, rd, er, w, t);
         e = sb.pop_front();
         total++;
         if (t || w != e.waits) begin
            bad++;
            $display("FAIL slverr[%0d] waits got=%0d exp=%0d timeout=%0b", i, w, e.waits, t);
         end
         total++;
         if (er !== e.err) begin
            bad++;
            $display("FAIL slverr[%0d] pslverr got=%b exp=%b", i, er, e.err);
         end
         if (e.chk) begin
            total++;
            if (rd !== e.data) begin
               bad++;
               $display("FAIL slverr[%0d] prdata got=%h exp=%h", i, rd, e.data);
            end
         end
      end
      idle();
   endtask

   task automatic test_abort();
      exp_t e;
      logic [31:0] rd;
      logic er, t;
      int w;
      sb.push_back('{1'b0, 32'h0, 1'b0, 3});
      xfer(1, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, rd, er, w, t);
      e = sb.pop_front();
      total++;
      if (t || w != e.waits || er !== e.err) begin
         bad++;
         $display("FAIL abort_prewrite got=%0d/%b exp=%0d/%b", w, er, e.waits, e.err);
      end
      @(posedge PCLK); #1;
      psel    = 2'b10;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 32'h30;
      PWDATA  = 32'hFFFFFFFF;
      PSTRB   = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      psel    = 2'b00;
      PENABLE = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge PCLK); #1;
         total++;
         if (pr3 !== 1'b0 || se3 !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle[%0d] ready/err got=%b%b exp=00", c, pr3, se3);
         end
      end
      sb.push_back('{1'b1, 32'h55AA55AA, 1'b0, 3});
      xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, w, t);
      e = sb.pop_front();
      total++;
      if (t || w != e.waits || er !== e.err || rd !== e.data) begin
         bad++;
         $display("FAIL abort_no_write got=%h/%0d/%b exp=%h/%0d/%b", rd, w, er, e.data, e.waits, e.err);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_back_to_back();
      test_wait_states();
      test_slverr();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
